// File: rtl/de_hazard_scoreboard.sv
// de_hazard_scoreboard
//   Tracks instructions that have left DE and have not yet been written back,
//   in issue order, as a circular queue of {valid, wr, rd} entries.
//   It produces the DE stall (RAW hazard or queue full), accepts issues,
//   retires the oldest entry at WB, and squashes the youngest entries when
//   AGEX flushes.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   issue_valid/wr/rd          decoded instruction presented by DE
//   rs1/rs1_used, rs2/rs2_used source operands of that instruction
//   retire_valid/retire_rd     WB completes the oldest in-flight instruction
//   flush_valid/flush_count    squash this many youngest entries
//   stall_out, issue_fire      combinational issue control for DE
//   occupancy, full, empty     registered queue status
//   retire_err                 sticky protocol error flag
module de_hazard_scoreboard #(
   parameter int DEPTH     = 4,
   parameter int REGNOBITS = 5,
   parameter int CNTBITS   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_valid,
   input  logic                 issue_wr,
   input  logic [REGNOBITS-1:0] issue_rd,
   input  logic [REGNOBITS-1:0] rs1,
   input  logic                 rs1_used,
   input  logic [REGNOBITS-1:0] rs2,
   input  logic                 rs2_used,
   input  logic                 retire_valid,
   input  logic [REGNOBITS-1:0] retire_rd,
   input  logic                 flush_valid,
   input  logic [CNTBITS-1:0]   flush_count,
   output logic                 stall_out,
   output logic                 issue_fire,
   output logic [CNTBITS-1:0]   occupancy,
   output logic                 full,
   output logic                 empty,
   output logic                 retire_err
);
   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]                r_vld;
   logic [DEPTH-1:0]                r_wr;
   logic [DEPTH-1:0][REGNOBITS-1:0] r_rd;
   logic [PTRW-1:0]                 r_head;
   logic [PTRW-1:0]                 r_tail;
   logic [CNTBITS-1:0]              r_occ;
   logic                            r_err;

   logic               w_ret_take;
   logic               w_haz1;
   logic               w_haz2;
   logic [CNTBITS-1:0] w_remain;
   logic [CNTBITS-1:0] w_n;
   logic [DEPTH-1:0]   w_sq;
   logic [PTRW-1:0]    w_dist;

   assign occupancy  = r_occ;
   assign full       = (r_occ == CNTBITS'(DEPTH));
   assign empty      = (r_occ == '0);
   assign retire_err = r_err;
   assign w_ret_take = retire_valid & ~empty;

   // The head entry being retired this cycle is skipped: the register file
   // is written on the negedge, so its value is already readable.
   always_comb begin
      w_haz1 = 1'b0;
      w_haz2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && r_wr[i] && !(w_ret_take && (PTRW'(i) == r_head))) begin
            if (rs1_used && (rs1 != '0) && (r_rd[i] == rs1)) w_haz1 = 1'b1;
            if (rs2_used && (rs2 != '0) && (r_rd[i] == rs2)) w_haz2 = 1'b1;
         end
      end
   end

   // Full stalls even when a retire frees a slot in the same cycle.
   assign stall_out  = issue_valid & (w_haz1 | w_haz2 | full);
   assign issue_fire = issue_valid & ~stall_out & ~flush_valid;

   // The flush acts on what is left after the same-cycle retire, so it can
   // never reach the head being retired.
   assign w_remain = r_occ - CNTBITS'(w_ret_take);
   assign w_n      = !flush_valid ? '0 :
                     (flush_count < w_remain) ? flush_count : w_remain;

   // An entry is squashed when its distance back from the tail is below n.
   always_comb begin
      w_sq   = '0;
      w_dist = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_dist  = r_tail - PTRW'(1) - PTRW'(i);
         w_sq[i] = (CNTBITS'(w_dist) < w_n);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld  <= '0;
         r_wr   <= '0;
         r_rd   <= '0;
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_ret_take) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + PTRW'(1);
            if (r_wr[r_head] && (r_rd[r_head] != retire_rd)) r_err <= 1'b1;
         end else if (retire_valid) begin
            r_err <= 1'b1;
         end
         for (int i = 0; i < DEPTH; i++)
            if (w_sq[i]) r_vld[i] <= 1'b0;
         // Issue and flush never coincide, so the tail moves one way only.
         if (issue_fire) begin
            r_vld[r_tail] <= 1'b1;
            r_wr[r_tail]  <= issue_wr;
            r_rd[r_tail]  <= issue_rd;
            r_tail        <= r_tail + PTRW'(1);
         end else begin
            r_tail <= r_tail - w_n[PTRW-1:0];
         end
         r_occ <= r_occ - CNTBITS'(w_ret_take) - w_n + CNTBITS'(issue_fire);
      end
   end
endmodule

// File: doc/de_hazard_scoreboard.md
Name: de_hazard_scoreboard

Overview:
In-order in-flight instruction tracker that sequences issue from the decode stage into the execute pipeline. Holds a circular queue with one entry per instruction issued from DE and not yet written back. Each entry records the destination register and a write-enable flag. Produces the DE stall (RAW hazard or queue full), retires entries in order at WB, and squashes the youngest entries on a branch flush from AGEX.

Parameters:
DEPTH, 4, queue entries (max in-flight instructions DE→WB); power of two, ≥2
REGNOBITS, 5, register-number width
CNTBITS, 3, occupancy/flush-count width; must hold DEPTH

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
issue_valid  in  1  DE holds a valid decoded instruction
issue_wr  in  1  instruction writes a destination register
issue_rd  in  REGNOBITS  destination register
rs1  in  REGNOBITS  source register 1
rs1_used  in  1  rs1 is read by the instruction
rs2  in  REGNOBITS  source register 2
rs2_used  in  1  rs2 is read by the instruction
retire_valid  in  1  WB completes the oldest in-flight instruction
retire_rd  in  REGNOBITS  WB destination register, checked against head entry
flush_valid  in  1  AGEX branch redirect
flush_count  in  CNTBITS  number of youngest entries to squash
stall_out  out  1  DE must hold; combinational
issue_fire  out  1  issue accepted this cycle; combinational
occupancy  out  CNTBITS  valid entries; registered
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
retire_err  out  1  sticky protocol error flag

Behaviour:
- Reset (synchronous): head=0, tail=0, occupancy=0, all entry valid bits=0, retire_err=0. This gives stall_out=0, full=0, empty=1. Reset asserted mid-operation discards all entries on that edge and overrides all other inputs.
- Entry fields: valid, wr, rd.
- Hazard check per source operand: the source matches if it is used, is nonzero, and some valid entry has wr=1 and the same rd. The entry being retired this cycle (head, when retire_valid=1) is excluded, because the register file is written on the negedge and the value is readable in the same cycle. x0 never causes a hazard.
- stall_out = issue_valid & (hazard_rs1 | hazard_rs2 | full). Full stalls even if a retire occurs in the same cycle; this is deliberately conservative.
- issue_fire = issue_valid & ~stall_out & ~flush_valid. On fire, write {1, issue_wr, issue_rd} to tail and advance tail modulo DEPTH. Every instruction gets an entry, including ones with issue_wr=0, so that retire stays in order.
- Retire: on retire_valid with empty=0, invalidate the head entry and advance head.
  - If the head has wr=1 and rd≠retire_rd, set retire_err.
  - retire_valid while empty sets retire_err; state is unchanged.
  - retire_err clears only on reset.
- Flush: applied after the same-cycle retire. Squash n = min(flush_count, remaining occupancy) youngest entries: clear their valid bits and set tail = tail − n modulo DEPTH. flush_count of 0 squashes nothing.
- Same-cycle events: reset overrides everything. Otherwise the order within one edge is retire, then flush; issue is suppressed whenever flush_valid=1.
- Occupancy update: next = occ − retire_taken − n + issue_fire, with no overflow by construction.
- Latency: an issued entry becomes visible to the hazard check on the next cycle. A retire clears the hazard in the same cycle.
- Pointers wrap modulo DEPTH. Full and empty are derived from occupancy, not from pointer equality.

Test Plan:
- Reset then issue ADD x5 (issue_wr=1, rd=5) → next cycle occupancy=1, empty=0. An instruction with rs1=5, rs1_used=1 gets stall_out=1 and issue_fire=0. The stall drops in the cycle retire_valid=1, retire_rd=5 is asserted, and issue_fire=1 in that cycle.
- Operand x0: an entry with rd=0, wr=1 is in flight and the new instruction uses rs1=0 → stall_out=0. A store (issue_wr=0, rd=7) is in flight and the new instruction reads x7 → stall_out=0.
- Issue 4 independent instructions → full=1, and a 5th independent instruction sees stall_out=1. In the cycle of one retire, stall_out is still 1. The next cycle the 5th issues and occupancy=4; the tail has wrapped to index 0.
- Occupancy=3 with flush_valid=1, flush_count=2, issue_valid=1 → issue_fire=0 and occupancy=1 next cycle. The hazards from the squashed rd values disappear, and only the head's rd still stalls.
- Occupancy=2 with retire_valid=1 and flush_count=3 in the same cycle → head retires, the remaining 1 entry is squashed, occupancy=0, empty=1, retire_err=0.
- retire_valid while empty, or retire_rd=9 against a head with rd=4, wr=1 → retire_err=1 and stays 1 until reset. The empty case leaves occupancy unchanged; the mismatch case still pops the head.
